o_reg_uart_tx: RTL and testbench
================================

# o_reg_uart_tx

Downstream consumer of the microprocessor's 4-bit output port `o_reg`. Every time `o_reg` changes value, the new nibble is queued in a small FIFO and transmitted as one uppercase ASCII hex character ('0'–'9', 'A'–'F') on a UART 8N1 serial line. The block lets a bench or board terminal log program output without halting the core, and it reports FIFO overflow when the program changes `o_reg` faster than the line can drain.

## Interface
Parameters:
- CLKS_PER_BIT, 16, clock cycles per UART bit; legal range ≥ 2.
- FIFO_DEPTH, 4, nibble FIFO entries; power of two, 2..16.

Ports:
- clk  in  1  system clock; the same clock that drives the microprocessor.
- reset  in  1  synchronous, active-high reset.
- o_reg  in  4  microprocessor output register; sampled every rising edge.
- tx  out  1  UART serial output; registered; idle high.
- busy  out  1  high while a frame is in progress (state ≠ IDLE).
- fifo_count  out  $clog2(FIFO_DEPTH)+1  number of queued nibbles.
- overflow  out  1  sticky; set when a change is dropped because the FIFO is full.

## Operation
- Change detect:
  - `prev` is a 4-bit register that resets to 4'h0.
  - At each edge where `o_reg != prev`, push `o_reg` into the FIFO and load `prev <= o_reg`.
  - A nonzero `o_reg` value seen after reset therefore produces a push.
- FIFO: circular buffer with read/write pointers and a count.
  - A push and a pop on the same edge leave the count unchanged.
  - A push when the FIFO is full and there is no pop on that edge: the data is dropped and `overflow <= 1`. `overflow` clears only on reset.
  - A push while full, on the same edge as a pop, is accepted.
  - Pop decisions use the registered count, so a value pushed at edge N cannot be popped before edge N+1.
- Encoding: for nibble v in 0..9, char = 8'h30 + v. For v in 10..15, char = 8'h37 + v, giving 'A'=8'h41 through 'F'=8'h46.
- Transmitter FSM, with bit counter `bcnt` (0..CLKS_PER_BIT-1) and bit index `idx` (0..7):
  - IDLE: `tx`=1. If `fifo_count` ≠ 0, pop, load the shift register with the encoded char, set `bcnt`=0, go to START.
  - START: `tx`=0 for CLKS_PER_BIT cycles, then go to DATA with `idx`=0.
  - DATA: `tx` = shift[0]. Every CLKS_PER_BIT cycles, shift right and increment `idx`. After bit 7 completes, go to STOP.
  - STOP: `tx`=1 for CLKS_PER_BIT cycles, then go to IDLE.
- Frame: 1 start bit, 8 data bits LSB first, 1 stop bit.
- Reset values: `tx`=1, `busy`=0, `fifo_count`=0, `overflow`=0, state IDLE, pointers 0, `prev`=0.
- Reset mid-frame aborts the frame immediately and flushes the FIFO. No partial frame resumes.

## Timing
- Latency from change to start bit: `o_reg` changes before edge N, so `fifo_count` increments at edge N. At edge N+1 the FSM pops, and `tx` falls after edge N+1.
- Frame length: exactly 10·CLKS_PER_BIT cycles from the `tx` falling edge to the end of the stop bit.
- Back-to-back: STOP exits to IDLE, and IDLE pops on the next edge. Consecutive start bits are therefore exactly 10·CLKS_PER_BIT+1 cycles apart, with 1 idle-high cycle between frames.
- Single-cycle `o_reg` glitches are captured. A→B→A over 2 cycles pushes both B and A.
- `busy` and `tx` are registered and never combinational from `o_reg`.

## Test plan
- Idle: reset, then hold `o_reg`=0 for 200 cycles → `tx`=1, `busy`=0, `fifo_count`=0, `overflow`=0 throughout.
- Digit, with CLKS_PER_BIT=4:
  - Stimulus: `o_reg` 0→5 before edge N.
  - Response: `fifo_count`=1 after N, `tx` low after N+1.
  - Bit sequence, 4 cycles each: 0, 1,0,1,0,1,1,0,0, 1 (8'h35 '5').
  - `busy` is high for exactly 40 cycles.
- Letters: `o_reg`=4'hA → data bits LSB first 1,0,0,0,0,0,1,0 (8'h41 'A'). Then 4'hF → 8'h46 'F', whose start bit begins 41 cycles after the 'A' start bit.
- Overflow, with FIFO_DEPTH=4:
  - Stimulus: `o_reg` = 1,2,3,4,5,6 on six consecutive edges.
  - Response: `fifo_count` goes 1,1,2,3,4,4. Value 6 is dropped and `overflow`=1.
  - Decoded output is '1','2','3','4','5'. `overflow` stays 1 after the line drains.
- Reset mid-frame:
  - Stimulus: assert `reset` for 1 cycle during data bit 3 with 2 entries queued.
  - Response: next edge `tx`=1, `busy`=0, `fifo_count`=0, `overflow`=0.
  - Then hold `o_reg`=0: no frame appears for 100 cycles.
- Glitch: `o_reg` 0→7→0 across 2 edges → two frames, '7' then '0'.

Source files
------------

// File: rtl/o_reg_uart_tx.sv
// Logs every change of o_reg as an ASCII hex char on a UART 8N1 line; start bit falls 2 edges after the change.
// No backpressure: changes arriving with the FIFO full (and no pop that edge) are dropped and flag sticky overflow.
module o_reg_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [3:0]                    o_reg,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BMAX = BW'(CLKS_PER_BIT - 1);
    localparam logic [PW:0]   FULL = (PW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t          state_q, state_d;
    logic [BW-1:0]   bcnt_q, bcnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            tx_q, tx_d;
    logic [3:0]      prev_q;
    logic [PW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
    logic [PW:0]     count_q, count_d;
    logic            ovf_q, ovf_d;
    logic [3:0]      mem_q [FIFO_DEPTH];

    logic            push, pop, accept;

    function automatic logic [7:0] enc(input logic [3:0] v);
        return (v < 4'd10) ? (8'h30 + {4'h0, v}) : (8'h37 + {4'h0, v});
    endfunction

    // Pop only looks at the registered count, so a fresh push waits one edge.
    assign push   = (o_reg != prev_q);
    assign pop    = (state_q == S_IDLE) && (count_q != '0);
    assign accept = push && ((count_q != FULL) || pop);

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        ovf_d   = ovf_q | (push && !accept);
        if (accept) wptr_d = wptr_q + PW'(1);
        if (pop)    rptr_d = rptr_q + PW'(1);
        if (accept && !pop)      count_d = count_q + (PW+1)'(1);
        else if (!accept && pop) count_d = count_q - (PW+1)'(1);
    end

    always_comb begin
        state_d = state_q;
        bcnt_d  = bcnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        tx_d    = 1'b1;
        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    shift_d = enc(mem_q[rptr_q]);
                    bcnt_d  = '0;
                    state_d = S_START;
                    tx_d    = 1'b0;
                end
            end
            S_START: begin
                tx_d = 1'b0;
                if (bcnt_q == BMAX) begin
                    bcnt_d  = '0;
                    idx_d   = 3'd0;
                    state_d = S_DATA;
                    tx_d    = shift_q[0];
                end else begin
                    bcnt_d = bcnt_q + BW'(1);
                end
            end
            S_DATA: begin
                tx_d = shift_q[0];
                if (bcnt_q == BMAX) begin
                    bcnt_d = '0;
                    if (idx_q == 3'd7) begin
                        state_d = S_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        shift_d = {1'b0, shift_q[7:1]};
                        idx_d   = idx_q + 3'd1;
                        tx_d    = shift_q[1];
                    end
                end else begin
                    bcnt_d = bcnt_q + BW'(1);
                end
            end
            S_STOP: begin
                if (bcnt_q == BMAX) begin
                    bcnt_d  = '0;
                    state_d = S_IDLE;
                end else begin
                    bcnt_d = bcnt_q + BW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            bcnt_q  <= '0;
            idx_q   <= 3'd0;
            shift_q <= 8'h00;
            tx_q    <= 1'b1;
            prev_q  <= 4'h0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bcnt_q  <= bcnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            prev_q  <= o_reg;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && accept) mem_q[wptr_q] <= o_reg;
    end

    assign tx         = tx_q;
    assign busy       = (state_q != S_IDLE);
    assign fifo_count = count_q;
    assign overflow   = ovf_q;
endmodule

// File: tb/tb_o_reg_uart_tx.sv
// Bench for o_reg_uart_tx: queue/timestamp reference model feeds expected chars to a UART-receiving monitor.
module tb_o_reg_uart_tx;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic       clk;
    logic       reset;
    logic [3:0] o_reg;
    logic       tx;
    logic       busy;
    logic [2:0] fifo_count;
    logic       overflow;

    o_reg_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .o_reg(o_reg), .tx(tx), .busy(busy),
        .fifo_count(fifo_count), .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    string      hexs = "0123456789ABCDEF";
    logic [3:0] mq[$];
    byte        exp_q[$];
    logic [3:0] mprev = 4'h0;
    bit         movf = 1'b0;
    int         cyc = 0;
    int         next_ok = 0;
    int         busy_end = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input logic [3:0] v, input logic r);
        logic [3:0] nib;
        o_reg = v;
        reset = r;
        @(posedge clk);
        #1;
        cyc++;
        if (r) begin
            mq.delete();
            exp_q.delete();
            movf     = 1'b0;
            mprev    = 4'h0;
            next_ok  = 0;
            busy_end = 0;
        end else begin
            if (mq.size() != 0 && cyc >= next_ok) begin
                nib = mq.pop_front();
                exp_q.push_back(byte'(hexs[nib]));
                next_ok  = cyc + 10*CPB + 1;
                busy_end = cyc + 10*CPB;
            end
            if (v != mprev) begin
                if (mq.size() < DEPTH) mq.push_back(v);
                else movf = 1'b1;
                mprev = v;
            end
        end
        chk("fifo_count", 32'(fifo_count), 32'(mq.size()));
        chk("overflow", 32'(overflow), 32'(movf));
        chk("busy", 32'(busy), 32'(cyc < busy_end));
        if (cyc >= busy_end) chk("tx_idle", 32'(tx), 32'd1);
    endtask

    // UART receiver monitor: samples mid-bit on negedges, pops the scoreboard per frame.
    bit      rx_act = 1'b0;
    int      rx_cnt = 0;
    logic [7:0] rx_byte;
    always @(negedge clk) begin
        int k;
        byte e;
        if (reset === 1'b1) begin
            rx_act = 1'b0;
        end else if (!rx_act) begin
            if (tx === 1'b0) begin
                rx_act = 1'b1;
                rx_cnt = 0;
            end
        end else begin
            rx_cnt++;
        end
        if (rx_act && reset === 1'b0 && (rx_cnt % CPB) == CPB/2) begin
            k = rx_cnt / CPB;
            if (k == 0) begin
                chk("start_bit", 32'(tx), 32'd0);
            end else if (k <= 8) begin
                rx_byte[k-1] = tx;
            end else begin
                chk("stop_bit", 32'(tx), 32'd1);
                rx_act = 1'b0;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL frame_unexpected: got char %0h expected no frame", rx_byte);
                end else begin
                    e = exp_q.pop_front();
                    chk("frame_char", 32'(rx_byte), 32'(e));
                end
            end
        end
    end

    logic [3:0] cur;
    int         ovf_cnt [6] = '{1, 1, 2, 3, 4, 4};

    initial begin
        o_reg = 4'h0;
        reset = 1'b1;
        repeat (3) step(4'h0, 1'b1);
        chk("reset_tx", 32'(tx), 32'd1);
        chk("reset_count", 32'(fifo_count), 32'd0);

        // Idle line
        repeat (200) step(4'h0, 1'b0);

        // Digit '5': count after edge N, start bit after N+1
        step(4'h5, 1'b0);
        chk("digit_count", 32'(fifo_count), 32'd1);
        chk("digit_tx_before", 32'(tx), 32'd1);
        step(4'h5, 1'b0);
        chk("digit_start", 32'(tx), 32'd0);
        repeat (50) step(4'h5, 1'b0);

        // Letters 'A' then 'F' back to back
        step(4'hA, 1'b0);
        repeat (10) step(4'hA, 1'b0);
        step(4'hF, 1'b0);
        repeat (90) step(4'hF, 1'b0);

        // Overflow: six changes on consecutive edges
        for (int i = 0; i < 6; i++) begin
            step(4'(i + 1), 1'b0);
            chk("ovf_seq_count", 32'(fifo_count), 32'(ovf_cnt[i]));
        end
        chk("ovf_set", 32'(overflow), 32'd1);
        repeat (250) step(4'h6, 1'b0);
        chk("ovf_sticky", 32'(overflow), 32'd1);

        // Reset during data bit 3 with two entries queued
        step(4'h8, 1'b0);
        step(4'h9, 1'b0);
        step(4'hC, 1'b0);
        repeat (15) step(4'hC, 1'b0);
        chk("pre_reset_count", 32'(fifo_count), 32'd2);
        step(4'h0, 1'b1);
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_count", 32'(fifo_count), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        repeat (100) step(4'h0, 1'b0);

        // Glitch 0->7->0
        step(4'h7, 1'b0);
        step(4'h0, 1'b0);
        repeat (100) step(4'h0, 1'b0);

        // Randomised changes, glitches and occasional resets
        cur = 4'h0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 5) == 0) cur = 4'($urandom_range(0, 15));
            step(cur, ($urandom_range(0, 799) == 0) ? 1'b1 : 1'b0);
        end

        // Drain, bounded
        for (int i = 0; i < 1000; i++) begin
            if (exp_q.size() == 0 && mq.size() == 0 && !rx_act && cyc >= busy_end) break;
            step(cur, 1'b0);
        end
        chk("drain_exp", 32'(exp_q.size()), 32'd0);
        chk("drain_fifo", 32'(mq.size()), 32'd0);
        chk("drain_rx_idle", 32'(rx_act), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
